// File: rtl/flt2fix_shift_sequencer.sv
// Multi-cycle IEEE-754 single to signed fixed-point converter with a one-bit-per-cycle shifter.
// Optional FLT2FIX_ROUND_EN: guard/sticky tracking on right shifts and round-half-away-from-zero.
module flt2fix_shift_sequencer #(
  parameter int P     = 32,
  parameter int EW    = 8,
  parameter int SW    = 23,
  parameter int FIX_W = 32,
  parameter int FRAC  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [P-1:0]     DATA_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [FIX_W-1:0] DATA_OUT,
  output logic             OVF
);

  localparam int CW = EW + 2;
  localparam logic signed [CW-1:0] OFFSET    = CW'((2 ** (EW - 1)) - 1 + SW - FRAC);
  localparam logic signed [CW-1:0] LEFT_MAX  = CW'(FIX_W - SW - 2);
  localparam logic signed [CW-1:0] RIGHT_MIN = CW'(-(SW + 1));
  localparam logic [FIX_W-1:0]     POS_MAX   = {1'b0, {(FIX_W-1){1'b1}}};
  localparam logic [FIX_W-1:0]     NEG_MAX   = {1'b1, {(FIX_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXP, SHIFT, FINISH} state_t;

  state_t            state;
  logic              sign;
  logic [EW-1:0]     exp_q;
  logic [FIX_W-1:0]  mag;
  logic [CW-1:0]     cnt;
  logic              left;
  logic              sat;
`ifdef FLT2FIX_ROUND_EN
  logic              guard;
  logic              sticky;
`endif

  logic signed [CW-1:0] s_val;
  logic [CW-1:0]        s_abs;
  logic                 exp_zero;
  logic                 exp_ones;
  logic [FIX_W:0]       rnd_mag;
  logic                 sat_final;
  logic [FIX_W-1:0]     fix_val;

  always_comb begin
    s_val    = $signed({2'b00, exp_q}) - OFFSET;
    s_abs    = s_val[CW-1] ? CW'(-s_val) : CW'(s_val);
    exp_zero = (exp_q == '0);
    exp_ones = (exp_q == '1);
`ifdef FLT2FIX_ROUND_EN
    rnd_mag  = {1'b0, mag} + {{FIX_W{1'b0}}, guard};
`else
    rnd_mag  = {1'b0, mag};
`endif
    // Rounding can carry past +max, so the final saturation check sees the widened sum.
    sat_final = sat | (rnd_mag > {1'b0, POS_MAX});
    fix_val   = sign ? (~rnd_mag[FIX_W-1:0] + 1'b1) : rnd_mag[FIX_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      sign     <= 1'b0;
      exp_q    <= '0;
      mag      <= '0;
      cnt      <= '0;
      left     <= 1'b0;
      sat      <= 1'b0;
`ifdef FLT2FIX_ROUND_EN
      guard    <= 1'b0;
      sticky   <= 1'b0;
`endif
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      DATA_OUT <= '0;
      OVF      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            sign  <= DATA_IN[P-1];
            exp_q <= DATA_IN[P-2 -: EW];
            mag   <= (DATA_IN[P-2 -: EW] == '0) ? '0
                     : {{(FIX_W-SW-1){1'b0}}, 1'b1, DATA_IN[SW-1:0]};
            cnt   <= '0;
            sat   <= 1'b0;
`ifdef FLT2FIX_ROUND_EN
            guard  <= 1'b0;
            sticky <= 1'b0;
`endif
            BUSY  <= 1'b1;
            state <= EXP;
          end
        end
        EXP: begin
          if (exp_zero) begin
            mag   <= '0;
            state <= FINISH;
          end else if (exp_ones || (s_val > LEFT_MAX)) begin
            sat   <= 1'b1;
            state <= FINISH;
          end else if (s_val < RIGHT_MIN) begin
            mag   <= '0;
            state <= FINISH;
          end else if (s_val == '0) begin
            state <= FINISH;
          end else begin
            cnt   <= s_abs;
            left  <= ~s_val[CW-1];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (left) begin
            mag <= mag << 1;
          end else begin
            mag <= mag >> 1;
`ifdef FLT2FIX_ROUND_EN
            guard  <= mag[0];
            sticky <= sticky | guard;
`endif
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FINISH;
        end
        FINISH: begin
          DATA_OUT <= sat_final ? (sign ? NEG_MAX : POS_MAX) : fix_val;
          OVF      <= sat_final;
          DONE     <= 1'b1;
          BUSY     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flt2fix_shift_sequencer.sv
// Randomized self-checking bench for flt2fix_shift_sequencer against a real-arithmetic reference.
module tb_flt2fix_shift_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [31:0] DATA_IN = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] DATA_OUT;
  logic        OVF;

  int checks = 0;
  int errors = 0;

  flt2fix_shift_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .DATA_IN(DATA_IN),
    .BUSY(BUSY), .DONE(DONE), .DATA_OUT(DATA_OUT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Value = 1.M * 2^(E-127) scaled by 2^16, then truncated or rounded; saturate beyond 32-bit signed.
  task automatic model(input logic [31:0] d, output logic [31:0] val, output logic ovf,
                       output int lat);
    int          e;
    int          s;
    real         mag_r;
    longint      mag;
    logic [31:0] mag_v;
    e = int'(d[30:23]);
    s = e - 134;
    val = '0;
    ovf = 1'b0;
    lat = (e == 0 || e == 255 || s > 7 || s < -24) ? 2 : 2 + ((s < 0) ? -s : s);
    if (e == 255) begin
      ovf = 1'b1;
      val = d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e != 0) begin
      mag_r = real'({1'b1, d[22:0]}) * $pow(2.0, real'(s));
`ifdef FLT2FIX_ROUND_EN
      mag_r = $floor(mag_r + 0.5);
`else
      mag_r = $floor(mag_r);
`endif
      if (mag_r > 2147483647.0) begin
        ovf = 1'b1;
        val = d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        mag   = longint'(mag_r);
        mag_v = mag[31:0];
        val   = d[31] ? (32'd0 - mag_v) : mag_v;
      end
    end
  endtask

  // Called between edges; returns #1 after the edge on which DONE rose.
  task automatic run_conv(input logic [31:0] d, input bit interfere);
    logic [31:0] exp_val;
    logic        exp_ovf;
    int          exp_lat;
    int          cyc;
    bit          busy_ok;
    model(d, exp_val, exp_ovf, exp_lat);
    START = 1'b1;
    DATA_IN = d;
    @(posedge CLK); #1;
    START = 1'b0;
    DATA_IN = $urandom;
    cyc = 0;
    busy_ok = 1'b1;
    while (!DONE && cyc < 64) begin
      if (!BUSY) busy_ok = 1'b0;
      @(posedge CLK); #1;
      cyc++;
      if (interfere && cyc == 2) begin START = 1'b1; DATA_IN = 32'h4000_0000; end
      if (interfere && cyc == 3) START = 1'b0;
    end
    if (!DONE) begin
      check_eq("done_timeout", 32'(DONE), 32'd1);
    end else begin
      check_eq("busy_hold", 32'(busy_ok), 32'd1);
      check_eq("latency", 32'(cyc), 32'(exp_lat));
      check_eq("data_out", DATA_OUT, exp_val);
      check_eq("ovf", 32'(OVF), 32'(exp_ovf));
      check_eq("busy_at_done", 32'(BUSY), 32'd0);
    end
  endtask

  task automatic done_pulse_check;
    @(posedge CLK); #1;
    check_eq("done_pulse", 32'(DONE), 32'd0);
  endtask

  logic [31:0] directed [12] = '{
    32'h3F80_0000, 32'hC020_0000, 32'h4700_0000, 32'hFF80_0000,
    32'h0000_0000, 32'h3F80_0040, 32'h8000_0000, 32'h7FC0_0000,
    32'h46FF_FFFF, 32'hC6FF_FFFF, 32'h3700_0001, 32'h3680_0000
  };

  initial begin
    int done_seen;
    logic [31:0] d;
    int e;

    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_done", 32'(DONE), 32'd0);
    check_eq("rst_data", DATA_OUT, 32'd0);
    check_eq("rst_ovf", 32'(OVF), 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    foreach (directed[i]) begin
      run_conv(directed[i], 1'b0);
      done_pulse_check();
    end

    run_conv(32'h3F80_0000, 1'b1);
    done_pulse_check();

    run_conv(32'h3F80_0000, 1'b0);
    run_conv(32'hC020_0000, 1'b0);
    done_pulse_check();

    START = 1'b1;
    DATA_IN = 32'h3F80_0000;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    check_eq("shift_busy", 32'(BUSY), 32'd1);
    RST = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(BUSY), 32'd0);
    check_eq("midrst_done", 32'(DONE), 32'd0);
    check_eq("midrst_data", DATA_OUT, 32'd0);
    check_eq("midrst_ovf", 32'(OVF), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    done_seen = 0;
    repeat (15) begin
      @(posedge CLK); #1;
      if (DONE) done_seen++;
    end
    check_eq("no_done_after_rst", 32'(done_seen), 32'd0);
    run_conv(32'h3F80_0000, 1'b0);
    done_pulse_check();

    for (int n = 0; n < 40; n++) begin
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(105, 145));
      d = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
      run_conv(d, 1'b0);
      if ($urandom_range(0, 1) == 1) done_pulse_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
